pc_fetch_ctrl: RTL

//  Owns the PC register and sequences instruction fetch: one outstanding req/gnt/rvalid transaction to IMEM.

---
 rtl/pc_fetch_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/pc_fetch_ctrl.sv
// PC owner and instruction-fetch sequencer: one outstanding req/gnt/rvalid transaction to IMEM,
// redirect/exception target generation, and a valid/stall handoff to decode.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_redir_valid,
  input  logic [1:0]  i_npc_op,
  input  logic [31:0] i_redir_pc,
  input  logic [25:0] i_imm,
  input  logic [31:0] i_reg_val,
  input  logic        i_exc_valid,
  input  logic        i_stall,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_inst_valid,
  output logic [31:0] o_inst,
  output logic [31:0] o_inst_pc,
  output logic [31:0] o_pc,
  output logic        o_flush
);

  typedef enum logic [1:0] {StBoot, StReq, StWait, StHold} state_e;

  localparam logic [1:0] NpcPlus4   = 2'b00;
  localparam logic [1:0] NpcBranch  = 2'b01;
  localparam logic [1:0] NpcJump    = 2'b10;
  localparam logic [1:0] NpcJumpReg = 2'b11;

  state_e      r_state;
  logic [31:0] r_pc;
  logic        r_kill;
  logic        r_inst_valid;
  logic [31:0] r_inst;
  logic [31:0] r_inst_pc;
  logic        r_flush;

  logic [31:0] w_p4;
  logic [31:0] w_target;
  logic        w_redirect;

  always_comb begin
    w_p4       = i_redir_pc + 32'd4;
    w_redirect = i_exc_valid | (i_redir_valid & (i_npc_op != NpcPlus4));
    w_target   = w_p4;
    if (i_exc_valid) begin
      w_target = EXC_VECTOR;
    end else begin
      case (i_npc_op)
        NpcBranch:  w_target = w_p4 + {{14{i_imm[15]}}, i_imm[15:0], 2'b00};
        NpcJump:    w_target = {w_p4[31:28], i_imm, 2'b00};
        NpcJumpReg: w_target = i_reg_val;
        default:    w_target = w_p4;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= StBoot;
      r_pc         <= RESET_PC;
      r_kill       <= 1'b0;
      r_inst_valid <= 1'b0;
      r_inst       <= 32'h0;
      r_inst_pc    <= 32'h0;
      r_flush      <= 1'b0;
    end else begin
      r_flush <= w_redirect;
      if (w_redirect) begin
        r_pc         <= w_target;
        r_inst_valid <= 1'b0;
      end
      case (r_state)
        StBoot: r_state <= StReq;
        StReq: begin
          // A granted fetch is already committed; a redirect can only mark it for dropping.
          if (i_imem_gnt) begin
            r_state <= StWait;
            r_kill  <= w_redirect;
          end
        end
        StWait: begin
          if (i_imem_rvalid) begin
            r_kill <= 1'b0;
            if (r_kill || w_redirect) begin
              r_state <= StReq;
            end else begin
              r_inst       <= i_imem_rdata;
              r_inst_pc    <= r_pc;
              r_pc         <= r_pc + 32'd4;
              r_inst_valid <= 1'b1;
              r_state      <= StHold;
            end
          end else if (w_redirect) begin
            r_kill <= 1'b1;
          end
        end
        StHold: begin
          if (w_redirect || !i_stall) begin
            r_inst_valid <= 1'b0;
            r_state      <= StReq;
          end
        end
        default: r_state <= StBoot;
      endcase
    end
  end

  assign o_imem_req   = (r_state == StReq);
  assign o_imem_addr  = r_pc;
  assign o_pc         = r_pc;
  assign o_inst_valid = r_inst_valid;
  assign o_inst       = r_inst;
  assign o_inst_pc    = r_inst_pc;
  assign o_flush      = r_flush;

endmodule
